// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared instruction encoding constants for the msrv32 front end
package msrv32_pkg;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int CSR_LSB    = 20;
  localparam int FUNCT7_LSB = 25;
  localparam int INSTR_LSB  = 7;

  localparam int OPCODE_W = 7;
  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;
  localparam int REG_W    = 5;
  localparam int CSR_W    = 12;
  localparam int INSTR_W  = 25;

endpackage

// File: rtl/msrv32_instr_fields.sv
// rtl/msrv32_instr_fields.sv - combinational splitter of a 32-bit instruction into decode fields
module msrv32_instr_fields
  import msrv32_pkg::*;
(
  input  logic [31:0]         instr_in,
  output logic [OPCODE_W-1:0] opcode_out,
  output logic [FUNCT3_W-1:0] funct3_out,
  output logic [FUNCT7_W-1:0] funct7_out,
  output logic [REG_W-1:0]    rs1addr_out,
  output logic [REG_W-1:0]    rs2addr_out,
  output logic [REG_W-1:0]    rdaddr_out,
  output logic [CSR_W-1:0]    csr_addr_out,
  output logic [INSTR_W-1:0]  instr_out
);

  assign opcode_out   = instr_in[OPCODE_LSB +: OPCODE_W];
  assign funct3_out   = instr_in[FUNCT3_LSB +: FUNCT3_W];
  assign funct7_out   = instr_in[FUNCT7_LSB +: FUNCT7_W];
  assign rs1addr_out  = instr_in[RS1_LSB    +: REG_W];
  assign rs2addr_out  = instr_in[RS2_LSB    +: REG_W];
  assign rdaddr_out   = instr_in[RD_LSB     +: REG_W];
  assign csr_addr_out = instr_in[CSR_LSB    +: CSR_W];
  assign instr_out    = instr_in[INSTR_LSB  +: INSTR_W];

endmodule

// File: rtl/msrv32_instr_queue_mux.sv
// rtl/msrv32_instr_queue_mux.sv - instruction/PC queue feeding decode with NOP substitution on flush or empty
module msrv32_instr_queue_mux
  import msrv32_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic                       ms_riscv32_mp_clk_in,
  input  logic                       ms_riscv32_mp_rst_n_in,
  input  logic                       flush_in,
  input  logic [31:0]                instr_in,
  input  logic [PC_W-1:0]            pc_in,
  input  logic                       instr_valid_in,
  output logic                       instr_ready_out,
  input  logic                       dec_ready_in,
  output logic                       dec_valid_out,
  output logic [OPCODE_W-1:0]        opcode_out,
  output logic [FUNCT3_W-1:0]        funct3_out,
  output logic [FUNCT7_W-1:0]        funct7_out,
  output logic [REG_W-1:0]           rs1addr_out,
  output logic [REG_W-1:0]           rs2addr_out,
  output logic [REG_W-1:0]           rdaddr_out,
  output logic [CSR_W-1:0]           csr_addr_out,
  output logic [INSTR_W-1:0]         instr_out,
  output logic [PC_W-1:0]            pc_out,
  output logic                       bubble_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = 32 + PC_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;
  logic [31:0]      w_sel;

  // Ready depends only on registered occupancy and flush, never on dec_ready_in.
  assign dec_valid_out   = (r_count != '0) & ~flush_in;
  assign instr_ready_out = (r_count != FULL_CNT) & ~flush_in;
  assign bubble_out      = ~dec_valid_out;
  assign count_out       = r_count;

  assign w_push = instr_valid_in & instr_ready_out;
  assign w_pop  = dec_valid_out & dec_ready_in;

  assign w_head = r_mem[r_rd_ptr];
  assign w_sel  = dec_valid_out ? w_head[ENT_W-1:PC_W] : NOP_INSTR;
  assign pc_out = dec_valid_out ? w_head[PC_W-1:0] : '0;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {instr_in, pc_in};
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  msrv32_instr_fields u_fields (
    .instr_in     (w_sel),
    .opcode_out   (opcode_out),
    .funct3_out   (funct3_out),
    .funct7_out   (funct7_out),
    .rs1addr_out  (rs1addr_out),
    .rs2addr_out  (rs2addr_out),
    .rdaddr_out   (rdaddr_out),
    .csr_addr_out (csr_addr_out),
    .instr_out    (instr_out)
  );

endmodule

// File: doc/msrv32_instr_queue_mux.md
Name: msrv32_instr_queue_mux

Overview:
Parametrised instruction queue plus field-extraction mux between instruction memory and the decode stage. Buffers up to DEPTH fetched instructions with their PCs, using valid/ready handshakes on both sides. Splits the head entry into opcode, funct, register and CSR fields. Presents the canonical NOP on every field when flushed or empty, and discards all queued entries on flush.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2
PC_W, 32, width of the PC carried with each instruction
NOP_INSTR, 32'h00000013, encoding presented when empty or flushed (ADDI x0,x0,0)

Ports:
ms_riscv32_mp_clk_in  input  1  clock, all state on rising edge
ms_riscv32_mp_rst_n_in  input  1  asynchronous active-low reset
flush_in  input  1  discard queue contents; force NOP at outputs this cycle
instr_in  input  32  fetched instruction
pc_in  input  PC_W  PC of instr_in
instr_valid_in  input  1  instr_in/pc_in valid
instr_ready_out  output  1  queue can accept an entry
dec_ready_in  input  1  decode consumes head this cycle
dec_valid_out  output  1  head entry valid
opcode_out  output  7  sel[6:0]
funct3_out  output  3  sel[14:12]
funct7_out  output  7  sel[31:25]
rs1addr_out  output  5  sel[19:15]
rs2addr_out  output  5  sel[24:20]
rdaddr_out  output  5  sel[11:7]
csr_addr_out  output  12  sel[31:20]
instr_out  output  25  sel[31:7]
pc_out  output  PC_W  PC of head; 0 when bubble
bubble_out  output  1  NOP being presented
count_out  output  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset is asynchronous, active-low, and fixed as such. On assertion: wr_ptr=0, rd_ptr=0, count=0. Storage RAM is not reset.
- Reset outputs: dec_valid_out=0, bubble_out=1, all fields decode NOP_INSTR (opcode=7'h13, others 0), pc_out=0, instr_ready_out=1, count_out=0.
- Reset mid-operation drops all entries immediately.
- sel = NOP_INSTR if (flush_in | count==0), else mem[rd_ptr]. All field outputs are combinational from sel.
- dec_valid_out = (count!=0) & ~flush_in.
- bubble_out = ~dec_valid_out.
- instr_ready_out = (count!=DEPTH) & ~flush_in. Registered-only dependency: no combinational path from dec_ready_in.
- push = instr_valid_in & instr_ready_out. On push, write {instr_in, pc_in} at wr_ptr; wr_ptr++.
- pop = dec_valid_out & dec_ready_in. On pop, rd_ptr++.
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- count next = count + push - pop.
- Simultaneous push and pop: count unchanged. Legal at any occupancy 1..DEPTH-1. At full, push is blocked; pop proceeds.
- Empty with push: entry is visible on the next cycle (1-cycle latency, no bypass). dec_valid_out stays 0 in the push cycle.
- Flush (flush_in=1): no push, no pop in that cycle. Next edge sets wr_ptr=rd_ptr=0 and count=0. Any instr_valid_in in the flush cycle is dropped.
- Flush held several cycles: queue stays empty; outputs stay NOP.
- Flush overrides every other event in the same cycle.
- instr_valid_in while not ready: the producer must hold. Block behaviour is identical whether held or dropped.
- Throughput: 1 push and 1 pop per cycle sustained.

Decomposition:
- Shared package msrv32_pkg:
  - NOP constant 32'h00000013
  - opcode/funct field bit-position localparams
  - field widths (7/3/7/5/12/25)
- One sub-module, msrv32_instr_fields: combinational 32-bit -> field splitter, reusable by other decode users.
- Queue storage and pointers stay inline.

Test Plan:
- Reset release, no input -> dec_valid_out=0, opcode_out=7'h13, rdaddr_out=0, instr_ready_out=1, count_out=0.
- Push 0x00A00093 (pc 0x100), dec_ready_in=0 -> next cycle dec_valid_out=1, opcode=7'h13, rd=1, rs1=0, csr_addr=12'h00A, pc_out=0x100, count=1.
- Push 4 entries, dec_ready_in=0 -> count=4, instr_ready_out=0; 5th valid not accepted. Then pop 4 -> entries returned in order across pointer wrap; count=0.
- count=2 with simultaneous push and pop -> count stays 2; order preserved.
- count=3 plus flush_in with instr_valid_in=1 -> same cycle fields=NOP, dec_valid_out=0, instr_ready_out=0; next cycle count=0 and the flushed-cycle instruction is absent.
- Deassert rst_n mid-stream with count=3 -> outputs immediately NOP, count_out=0, no clock edge required.
